pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It drives the enable (`cpu_en`-style) and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, taken-branch squashes and multi-cycle data-RAM accesses through a req/ack handshake with a timeout watchdog. It sits beside the datapath and owns no datapath state, only control and performance counters.

---
 rtl/pipeline_hazard_controller_pkg.sv | 32 +++
 rtl/pipeline_hazard_controller_hazard_detect.sv | 27 ++
 rtl/pipeline_hazard_controller.sv | 153 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions: sequencer states, the pipeline-register control
// bundle and the bubble encodings loaded by a flush.
package pipeline_hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    localparam int unsigned WAIT_CNT_W = 8;

    // Instruction word the pipeline registers load on a flush.
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Fully frozen pipeline: nothing enabled, nothing flushed.
    localparam pipe_ctrl_t CTRL_FROZEN = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    localparam pipe_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Load-use hazard comparator between the ID sources and the EX load destination.
module hazard_detect
    import pipeline_hazard_controller_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rs_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_is_load_i,
    input  logic       ex_writes_rf_i,
    input  logic [4:0] ex_wr_addr_i,
    output logic       luh_o
);

    logic rs_hit_s;
    logic rt_hit_s;
    logic ex_load_dest_s;

    // $0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        ex_load_dest_s = ex_is_load_i & ex_writes_rf_i & (ex_wr_addr_i != 5'd0);
        rs_hit_s       = id_uses_rs_i & (id_rs_i == ex_wr_addr_i);
        rt_hit_s       = id_uses_rt_i & (id_rt_i == ex_wr_addr_i);
        luh_o          = ex_load_dest_s & (rs_hit_s | rt_hit_s);
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// data-RAM wait states with a watchdog, and a saturating stall counter.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_en,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_usesRs,
    input  logic                   id_usesRt,
    input  logic                   id_branchTaken,
    input  logic                   ex_memOutOrAluOutWriteBackToRegFile,
    input  logic                   ex_ifWriteRegsFile,
    input  logic [4:0]             ex_registerWriteAddress,
    input  logic                   mem_memAccess,
    input  logic                   dram_ack,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   memwb_flush,
    output logic                   dram_req,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Counter value seen in the last ack-less wait cycle before the watchdog fires.
    localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    hz_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   timeout_q, timeout_d;

    logic       luh_s;
    logic       mst_s;
    pipe_ctrl_t ctrl_s;

    hazard_detect u_hazard_detect (
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rs_i   (id_usesRs),
        .id_uses_rt_i   (id_usesRt),
        .ex_is_load_i   (ex_memOutOrAluOutWriteBackToRegFile),
        .ex_writes_rf_i (ex_ifWriteRegsFile),
        .ex_wr_addr_i   (ex_registerWriteAddress),
        .luh_o          (luh_s)
    );

    assign mst_s = mem_memAccess & ~dram_ack;

    // Output decode in priority order: frozen/error > memory stall > load-use > branch.
    always_comb begin
        ctrl_s = CTRL_NORMAL;
        if (rst || !cpu_en || (state_q == ST_ERROR)) begin
            ctrl_s = CTRL_FROZEN;
        end else if (mst_s) begin
            ctrl_s             = CTRL_FROZEN;
            ctrl_s.memwb_en    = 1'b1;
            ctrl_s.memwb_flush = 1'b1;
        end else if (luh_s) begin
            ctrl_s.pc_en      = 1'b0;
            ctrl_s.ifid_en    = 1'b0;
            ctrl_s.idex_flush = 1'b1;
        end else if (id_branchTaken) begin
            ctrl_s.ifid_flush = 1'b1;
        end else begin
            ctrl_s = CTRL_NORMAL;
        end
    end

    assign pc_en        = ctrl_s.pc_en;
    assign ifid_en      = ctrl_s.ifid_en;
    assign idex_en      = ctrl_s.idex_en;
    assign exmem_en     = ctrl_s.exmem_en;
    assign memwb_en     = ctrl_s.memwb_en;
    assign ifid_flush   = ctrl_s.ifid_flush;
    assign idex_flush   = ctrl_s.idex_flush;
    assign memwb_flush  = ctrl_s.memwb_flush;
    assign dram_req     = mem_memAccess & cpu_en & ~rst & (state_q != ST_ERROR);
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

    // Next-state logic; everything holds while cpu_en is low.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;
        timeout_d  = timeout_q;
        if (cpu_en) begin
            if (!ctrl_s.pc_en && (stall_q != {STALL_CNT_W{1'b1}})) begin
                stall_d = stall_q + STALL_ONE;
            end else begin
                stall_d = stall_q;
            end
            case (state_q)
                ST_RUN: begin
                    if (mst_s) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    // An ack in the limit cycle still wins over the watchdog.
                    if (dram_ack) begin
                        state_d = ST_RUN;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d    = ST_ERROR;
                        timeout_d  = 1'b1;
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: directed hazard scenarios then random traffic, checked against
// a request-age reference model of the stall/flush rules.
module tb_pipeline_hazard_controller;

    localparam int T  = 4;
    localparam int SW = 5;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cpu_en;
    logic [4:0] id_rs, id_rt, ex_wa;
    logic id_uses_rs, id_uses_rt, id_br, ex_load, ex_wr, mem_acc, ack;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush, dram_req, mem_timeout;
    logic [SW-1:0] stall_cycles;

    pipeline_hazard_controller #(.TIMEOUT_CYCLES(T), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_uses_rs), .id_usesRt(id_uses_rt),
        .id_branchTaken(id_br),
        .ex_memOutOrAluOutWriteBackToRegFile(ex_load), .ex_ifWriteRegsFile(ex_wr),
        .ex_registerWriteAddress(ex_wa),
        .mem_memAccess(mem_acc), .dram_ack(ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .dram_req(dram_req), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic [8:0]    ctrl;   // pc,ifid,idex,exmem,memwb,ifid_f,idex_f,memwb_f,req
        logic          to;
        logic [SW-1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: age of the outstanding RAM request in request cycles.
    bit m_err = 1'b0;
    int m_age = 0;
    int m_stall = 0;

    function automatic logic [8:0] model_ctrl();
        logic luh;
        luh = ex_load && ex_wr && (ex_wa != 5'd0) &&
              ((id_uses_rs && id_rs == ex_wa) || (id_uses_rt && id_rt == ex_wa));
        if (rst || !cpu_en || m_err) return 9'b00000_000_0;
        if (mem_acc && !ack)         return 9'b00001_001_1;
        if (luh)                     return {8'b00111_010, mem_acc};
        if (id_br)                   return {8'b11111_100, mem_acc};
        return {8'b11111_000, mem_acc};
    endfunction

    task automatic step(input bit chk);
        exp_t e;
        e.ctrl = model_ctrl();
        e.to   = m_err;
        e.st   = SW'(m_stall);
        if (chk) exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_err = 1'b0; m_age = 0; m_stall = 0;
        end else if (cpu_en) begin
            if (!e.ctrl[8] && m_stall < STALL_MAX) m_stall++;
            if (!m_err) begin
                if (mem_acc && !ack) begin
                    m_age++;
                    if (m_age == T + 1) m_err = 1'b1;
                end else begin
                    m_age = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; cpu_en = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_wa = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_br = 1'b0; ex_load = 1'b0;
        ex_wr = 1'b0; mem_acc = 1'b0; ack = 1'b0;
    endtask

    // Monitor: outputs are valid every cycle; sample on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 3;
                if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                     memwb_flush, dram_req} !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl @%0t: got %b expected %b", $time,
                             {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
                              idex_flush, memwb_flush, dram_req}, e.ctrl);
                end
                if (mem_timeout !== e.to) begin
                    errors++;
                    $display("FAIL mem_timeout @%0t: got %b expected %b", $time, mem_timeout, e.to);
                end
                if (stall_cycles !== e.st) begin
                    errors++;
                    $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, stall_cycles, e.st);
                end
            end
        end
    end

    initial begin
        bit req_active = 1'b0;
        int lat = 0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        step(1'b0);
        step(1'b1);
        rst = 1'b0;
        step(1'b1);

        // Load-use on rs: one bubble, then normal once EX holds the bubble.
        ex_load = 1'b1; ex_wr = 1'b1; ex_wa = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
        step(1'b1);
        ex_load = 1'b0; ex_wr = 1'b0; ex_wa = 5'd0;
        step(1'b1);
        // Load to $0 read by ID: no stall.
        ex_load = 1'b1; ex_wr = 1'b1; ex_wa = 5'd0; id_rs = 5'd0;
        step(1'b1);
        // Load-use plus taken branch: bubble first, squash next cycle.
        ex_wa = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_uses_rs = 1'b0; id_br = 1'b1;
        step(1'b1);
        ex_load = 1'b0; ex_wr = 1'b0;
        step(1'b1);
        idle_inputs();
        // Store acked 3 cycles after request; zero-wait access right after.
        mem_acc = 1'b1;
        repeat (3) step(1'b1);
        ack = 1'b1;
        step(1'b1);
        step(1'b1);
        // Wait interrupted by cpu_en low for 2 cycles.
        ack = 1'b0;
        repeat (2) step(1'b1);
        cpu_en = 1'b0;
        repeat (2) step(1'b1);
        cpu_en = 1'b1;
        step(1'b1);
        ack = 1'b1;
        step(1'b1);
        // Watchdog: no ack, error after T+1 request cycles; reset clears it.
        ack = 1'b0;
        repeat (T + 3) step(1'b1);
        rst = 1'b1;
        step(1'b1);
        idle_inputs();
        step(1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst    = (m_err && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
            cpu_en = ($urandom_range(0, 9) != 0);
            if (!req_active && $urandom_range(0, 3) == 0) begin
                req_active = 1'b1;
                lat = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 5));
            end
            mem_acc    = req_active;
            ack        = req_active && (m_age == lat);
            ex_load    = $urandom_range(0, 1) != 0;
            ex_wr      = $urandom_range(0, 3) != 0;
            ex_wa      = 5'($urandom_range(0, 3));
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            id_uses_rs = $urandom_range(0, 1) != 0;
            id_uses_rt = $urandom_range(0, 1) != 0;
            id_br      = $urandom_range(0, 3) == 0;
            if (rst || (ack && cpu_en && !m_err)) req_active = 1'b0;
            step(1'b1);
        end

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
